// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit FIFO: register offsets, STATUS/CTRL
// bit positions and the drain state encoding.
package serial_pkg;

  // Register select values, taken from addr[3:2].
  localparam logic [1:0] RegData   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCtrl   = 2'd2;
  localparam logic [1:0] RegRsvd   = 2'd3;

  // STATUS layout: {16'b0, level[7:0], 6'b0, full, empty}.
  localparam int unsigned StatusEmptyBit = 0;
  localparam int unsigned StatusFullBit  = 1;
  localparam int unsigned StatusLevelLsb = 8;

  // CTRL layout: bit 0 flush (write-only), bits 15:8 low-level threshold.
  localparam int unsigned CtrlFlushBit  = 0;
  localparam int unsigned CtrlThreshLsb = 8;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } drain_state_e;

endpackage

// File: rtl/serial_fifo_mem.sv
// Byte storage for the transmit FIFO: DEPTH x 8, one synchronous write port and
// one asynchronous read port. No reset; validity is tracked by the controller.
module serial_fifo_mem #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [7:0]               wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [7:0]               rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/serial_tx_fifo.sv
// Bus-mapped transmit FIFO feeding a UART data register.
// Optional feature: define SERIAL_TX_FIFO_IRQ_EN for the programmable
// low-level interrupt and readable threshold; otherwise irq_o is tied low.
module serial_tx_fifo
  import serial_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned RESET_THRESH = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        uart_we_o,
  output logic [7:0]  uart_di_o,
  input  logic        uart_wait_i,
  output logic        irq_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  drain_state_e  state_q;
  logic          uart_we_q;
  logic [7:0]    uart_di_q;
  logic [7:0]    head_byte;
  logic [7:0]    level;
  logic [7:0]    thresh;
  logic [1:0]    reg_sel;
  logic          is_wr, data_wr, ctrl_wr, flush, push, pop, full, empty;

  assign reg_sel = addr_i[3:2];
  assign is_wr   = |wstrb_i;
  assign data_wr = valid_i && is_wr && (reg_sel == RegData);
  assign ctrl_wr = valid_i && is_wr && (reg_sel == RegCtrl);
  assign flush   = ctrl_wr && wdata_i[CtrlFlushBit];

  // Flags come from the registered count only, so a pop cannot make room for
  // a push in the same cycle.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign level = 8'(count_q);

  assign ready_o = valid_i && !(data_wr && full);
  assign push    = data_wr && !full && !flush;
  assign pop     = uart_we_q && !uart_wait_i;

  // Read mux; the bus sees zero whenever the access is not completing.
  always_comb begin
    rdata_o = '0;
    if (ready_o) begin
      unique case (reg_sel)
        RegStatus: begin
          rdata_o[StatusEmptyBit]        = empty;
          rdata_o[StatusFullBit]         = full;
          rdata_o[StatusLevelLsb +: 8]   = level;
        end
        RegCtrl:   rdata_o[CtrlThreshLsb +: 8] = thresh;
        RegData, RegRsvd: rdata_o = '0;
        default:   rdata_o = '0;
      endcase
    end
  end

  // Pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Reading at rd_ptr_d gives the current head in IDLE and the following
  // entry right after a pop, so one read port serves both FSM transitions.
  serial_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_i[7:0]),
    .raddr_i (rd_ptr_d),
    .rdata_o (head_byte)
  );

  // Drain FSM with registered UART strobe and data.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      uart_we_q <= 1'b0;
      uart_di_q <= '0;
    end else if (flush) begin
      state_q   <= StIdle;
      uart_we_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            state_q   <= StSend;
            uart_we_q <= 1'b1;
            uart_di_q <= head_byte;
          end
        end
        StSend: begin
          if (pop) begin
            if (count_q > CW'(1)) begin
              uart_di_q <= head_byte;
            end else begin
              state_q   <= StIdle;
              uart_we_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          uart_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign uart_we_o = uart_we_q;
  assign uart_di_o = uart_di_q;

`ifdef SERIAL_TX_FIFO_IRQ_EN
  logic [7:0] thresh_q, thresh_d;
  logic       irq_q;

  // Threshold is updated by any CTRL write, flush or not.
  always_comb begin
    thresh_d = thresh_q;
    if (ctrl_wr) thresh_d = wdata_i[CtrlThreshLsb +: 8];
  end

  // irq follows the occupancy that becomes visible after this edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      thresh_q <= 8'(RESET_THRESH);
      irq_q    <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      irq_q    <= (9'(count_d) <= 9'(thresh_d));
    end
  end

  assign thresh = thresh_q;
  assign irq_o  = irq_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^{wdata_i[15:8], 8'(RESET_THRESH)};
  assign thresh        = '0;
  assign irq_o         = 1'b0;
`endif

  logic unused_bus;
  assign unused_bus = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:16]};

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Self-checking bench for serial_tx_fifo; bytes accepted by the UART are
// collected and compared against a queue-based model of pushes and level.
module tb_serial_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] ADDR_DATA   = 32'h0;
  localparam logic [31:0] ADDR_STATUS = 32'h4;
  localparam logic [31:0] ADDR_CTRL   = 32'h8;
  localparam logic [31:0] ADDR_RSVD   = 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [3:0]  wstrb = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        uart_wait = 1'b0;
  logic        ready, uart_we, irq;
  logic [31:0] rdata;
  logic [7:0]  uart_di;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_push = 0;

  logic [7:0] acc_q[$];
  int         acc_t[$];
  logic       pend = 1'b0;
  logic [7:0] pend_b = '0;

  serial_tx_fifo #(
    .DEPTH        (DEPTH),
    .RESET_THRESH (0)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .valid_i     (valid),
    .ready_o     (ready),
    .wstrb_i     (wstrb),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .uart_we_o   (uart_we),
    .uart_di_o   (uart_di),
    .uart_wait_i (uart_wait),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART side: sample handshake mid-cycle, log the byte when the edge commits it.
  always @(negedge clk) begin
    pend   <= uart_we && !uart_wait;
    pend_b <= uart_di;
  end
  always @(posedge clk) begin
    if (pend) begin
      acc_q.push_back(pend_b);
      acc_t.push_back(cyc);
    end
  end

  // Expected STATUS from model occupancy = committed pushes - committed accepts.
  function automatic logic [31:0] status_exp();
    int lvl;
    lvl = n_push - acc_q.size();
    return {16'b0, 8'(lvl), 6'b0, lvl == DEPTH, lvl == 0};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; valid = 1'b0; wstrb = '0; uart_wait = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    acc_q.delete(); acc_t.delete(); n_push = 0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int stalls);
    logic ok;
    logic [1:0] sel;
    valid = 1'b1; wstrb = 4'hf; addr = a; wdata = d; stalls = 0;
    @(negedge clk);
    while (!ready && stalls < 400) begin
      stalls++;
      @(negedge clk);
    end
    ok = ready;
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bus_write_timeout addr=%h: ready=%b, required 1", a, ok);
    end
    @(posedge clk);
    #1;
    valid = 1'b0; wstrb = '0;
    sel = a[3:2];
    if (ok && sel == 2'd0) n_push++;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    valid = 1'b1; wstrb = '0; addr = a;
    @(negedge clk);
    d = rdata;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int st;
    reset = 1'b1; uart_wait = 1'b0; valid = 1'b1; wstrb = '0; addr = ADDR_STATUS;
    tick(2);
    @(negedge clk);
    n_cmp++;
    if (uart_we !== 1'b0 || uart_di !== 8'h00 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: we=%b di=%h irq=%b, required 0 00 0", uart_we, uart_di, irq);
    end
    n_cmp++;
    if (ready !== 1'b1 || rdata !== 32'h1) begin
      n_fail++;
      $display("FAIL reset_status: ready=%b rdata=%h, required 1 00000001", ready, rdata);
    end
    @(posedge clk);
    #1;
    valid = 1'b0; reset = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_bus: ready=%b rdata=%h, required 0 00000000", ready, rdata);
    end
    tick(1);
    acc_q.delete(); acc_t.delete(); n_push = 0;
    bus_read(ADDR_CTRL, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rdata=%h, required 00000000", d);
    end
    bus_write(ADDR_RSVD, 32'hffff_ffff, st);
    bus_read(ADDR_RSVD, d);
    n_cmp++;
    if (d !== 32'h0 || st != 0) begin
      n_fail++;
      $display("FAIL rsvd_reg: rdata=%h stalls=%0d, required 00000000 0", d, st);
    end
    bus_read(ADDR_STATUS, d);
    n_cmp++;
    if (d !== status_exp()) begin
      n_fail++;
      $display("FAIL rsvd_no_effect: status=%h, required %h", d, status_exp());
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    int k;
    do_reset();
    valid = 1'b1; wstrb = 4'hf; addr = ADDR_DATA; wdata = 32'h41;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1 || uart_we !== 1'b0) begin
      n_fail++;
      $display("FAIL push_latency: ready=%b uart_we=%b, required 1 0", ready, uart_we);
    end
    @(posedge clk);
    #1;
    n_push++;
    wdata = 32'h42;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL second_push_ready: ready=%b, required 1", ready);
    end
    @(posedge clk);
    #1;
    n_push++;
    valid = 1'b0; wstrb = '0;
    k = 0;
    while (acc_q.size() < 2 && k < 20) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (acc_q.size() != 2) begin
      n_fail++;
      $display("FAIL basic_count: accepted=%0d, required 2", acc_q.size());
    end else begin
      n_cmp++;
      if (acc_q[0] !== 8'h41 || acc_q[1] !== 8'h42) begin
        n_fail++;
        $display("FAIL basic_order: got %h %h, required 41 42", acc_q[0], acc_q[1]);
      end
      n_cmp++;
      if (acc_t[1] - acc_t[0] != 1) begin
        n_fail++;
        $display("FAIL basic_consecutive: gap=%0d, required 1", acc_t[1] - acc_t[0]);
      end
    end
    tick(2);
    bus_read(ADDR_STATUS, d);
    n_cmp++;
    if (d !== 32'h1 || uart_we !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_empty: status=%h we=%b, required 00000001 0", d, uart_we);
    end
  endtask

  task automatic test_full();
    logic [7:0]  exp[$];
    logic [7:0]  b;
    logic [31:0] d;
    int st, tot, bad, k;
    do_reset();
    uart_wait = 1'b1;
    tot = 0;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      exp.push_back(b);
      bus_write(ADDR_DATA, {24'h0, b}, st);
      tot += st;
    end
    n_cmp++;
    if (tot != 0) begin
      n_fail++;
      $display("FAIL full_fill_stalls: stalls=%0d, required 0", tot);
    end
    bus_read(ADDR_STATUS, d);
    n_cmp++;
    if (d !== status_exp() || d !== 32'h0000_1002) begin
      n_fail++;
      $display("FAIL full_status: status=%h, required 00001002", d);
    end
    b = 8'($urandom);
    valid = 1'b1; wstrb = 4'hf; addr = ADDR_DATA; wdata = {24'h0, b};
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL full_stall: ready-high cycles=%0d, required 0", bad);
    end
    uart_wait = 1'b0;
    st = 0;
    @(negedge clk);
    while (!ready && st < 20) begin
      st++;
      @(negedge clk);
    end
    n_cmp++;
    if (ready !== 1'b1 || st != 1) begin
      n_fail++;
      $display("FAIL full_release: ready=%b stall=%0d, required 1 1", ready, st);
    end
    @(posedge clk);
    #1;
    valid = 1'b0; wstrb = '0;
    n_push++;
    exp.push_back(b);
    k = 0;
    while (acc_q.size() < exp.size() && k < 100) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (acc_q.size() != exp.size()) begin
      n_fail++;
      $display("FAIL full_drain_count: accepted=%0d, required %0d", acc_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_cmp++;
        if (acc_q[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL full_byte[%0d]: got %h, required %h", i, acc_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] d;
    int st, bad, k;
    do_reset();
    uart_wait = 1'b1;
    bus_write(ADDR_DATA, 32'h55, st);
    k = 0;
    while (uart_we !== 1'b1 && k < 5) begin
      tick(1);
      k++;
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uart_we !== 1'b1 || uart_di !== 8'h55) bad++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bad != 0 || acc_q.size() != 0) begin
      n_fail++;
      $display("FAIL hold_stable: bad cycles=%0d pops=%0d, required 0 0", bad, acc_q.size());
    end
    bus_read(ADDR_STATUS, d);
    n_cmp++;
    if (d !== status_exp() || d !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL hold_status: status=%h, required 00000100", d);
    end
    uart_wait = 1'b0;
    tick(4);
    n_cmp++;
    if (acc_q.size() != 1 || uart_we !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: accepted=%0d we=%b, required 1 0", acc_q.size(), uart_we);
    end else begin
      n_cmp++;
      if (acc_q[0] !== 8'h55) begin
        n_fail++;
        $display("FAIL hold_byte: got %h, required 55", acc_q[0]);
      end
    end
  endtask

  task automatic test_flush();
    int st, k;
    do_reset();
    uart_wait = 1'b1;
    for (int i = 0; i < 5; i++) bus_write(ADDR_DATA, 32'($urandom_range(0, 255)), st);
    bus_write(ADDR_CTRL, 32'h1, st);
    acc_q.delete(); acc_t.delete(); n_push = 0;
    valid = 1'b1; wstrb = '0; addr = ADDR_STATUS;
    @(negedge clk);
    n_cmp++;
    if (uart_we !== 1'b0 || rdata !== status_exp() || rdata !== 32'h1) begin
      n_fail++;
      $display("FAIL flush_state: we=%b status=%h, required 0 00000001", uart_we, rdata);
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    uart_wait = 1'b0;
    bus_write(ADDR_DATA, 32'h77, st);
    k = 0;
    while (acc_q.size() < 1 && k < 20) begin
      tick(1);
      k++;
    end
    tick(3);
    n_cmp++;
    if (acc_q.size() != 1) begin
      n_fail++;
      $display("FAIL flush_after_count: accepted=%0d, required 1", acc_q.size());
    end else begin
      n_cmp++;
      if (acc_q[0] !== 8'h77) begin
        n_fail++;
        $display("FAIL flush_after_byte: got %h, required 77", acc_q[0]);
      end
    end
  endtask

`ifdef SERIAL_TX_FIFO_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    int st, bad;
    do_reset();
    uart_wait = 1'b1;
    bus_write(ADDR_CTRL, 32'h0000_0200, st);
    bus_read(ADDR_CTRL, d);
    n_cmp++;
    if (d !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL irq_thresh_read: rdata=%h, required 00000200", d);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_empty: irq=%b, required 1", irq);
    end
    tick(1);
    for (int i = 0; i < 4; i++) bus_write(ADDR_DATA, 32'($urandom_range(0, 255)), st);
    tick(2);
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_above: irq=%b level=%0d, required 0", irq, n_push - acc_q.size());
    end
    @(posedge clk);
    #1;
    uart_wait = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (irq !== ((n_push - acc_q.size()) <= 2)) bad++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (bad != 0 || irq !== 1'b1 || acc_q.size() != 4) begin
      n_fail++;
      $display("FAIL irq_track: bad=%0d irq=%b sent=%0d, required 0 1 4", bad, irq, acc_q.size());
    end
  endtask
`else
  task automatic test_irq();
    logic [31:0] d;
    int st, bad;
    do_reset();
    bus_write(ADDR_CTRL, 32'h0000_0300, st);
    bus_read(ADDR_CTRL, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL no_irq_thresh: rdata=%h, required 00000000", d);
    end
    uart_wait = 1'b1;
    bus_write(ADDR_DATA, 32'h12, st);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (irq !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    uart_wait = 1'b0;
    tick(4);
    n_cmp++;
    if (bad != 0 || irq !== 1'b0 || acc_q.size() != 1) begin
      n_fail++;
      $display("FAIL no_irq_tied: bad=%0d irq=%b sent=%0d, required 0 0 1", bad, irq, acc_q.size());
    end
  endtask
`endif

  task automatic test_reset_mid();
    int st, k;
    do_reset();
    uart_wait = 1'b1;
    for (int i = 0; i < 3; i++) bus_write(ADDR_DATA, 32'($urandom_range(0, 255)), st);
    k = 0;
    while (uart_we !== 1'b1 && k < 5) begin
      tick(1);
      k++;
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    valid = 1'b1; wstrb = '0; addr = ADDR_STATUS;
    @(negedge clk);
    n_cmp++;
    if (uart_we !== 1'b0 || irq !== 1'b0 || rdata !== 32'h1 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: we=%b irq=%b status=%h ready=%b, required 0 0 00000001 1",
               uart_we, irq, rdata, ready);
    end
    @(posedge clk);
    #1;
    valid = 1'b0; uart_wait = 1'b0;
    acc_q.delete(); acc_t.delete(); n_push = 0;
    tick(4);
    n_cmp++;
    if (acc_q.size() != 0 || uart_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_dropped: sent=%0d we=%b, required 0 0", acc_q.size(), uart_we);
    end
  endtask

  task automatic test_random();
    logic [7:0]  exp[$];
    logic [7:0]  prev_di;
    logic [7:0]  b;
    logic [31:0] d;
    logic        prev_hold;
    bit          wr_done;
    int          st, k;
    do_reset();
    wr_done = 1'b0;
    fork
      begin
        prev_hold = 1'b0;
        prev_di   = '0;
        while (!wr_done) begin
          @(negedge clk);
          if (prev_hold) begin
            n_cmp++;
            if (uart_we !== 1'b1 || uart_di !== prev_di) begin
              n_fail++;
              $display("FAIL rand_hold: we=%b di=%h, required 1 %h", uart_we, uart_di, prev_di);
            end
          end
          prev_hold = uart_we && uart_wait;
          prev_di   = uart_di;
          @(posedge clk);
          #1;
          uart_wait = ($urandom_range(0, 1) != 0);
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          b = 8'($urandom);
          bus_write(ADDR_DATA, {24'h0, b}, st);
          exp.push_back(b);
          tick($urandom_range(0, 3));
        end
        wr_done = 1'b1;
      end
    join
    uart_wait = 1'b0;
    k = 0;
    while (acc_q.size() < exp.size() && k < 200) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (acc_q.size() != exp.size()) begin
      n_fail++;
      $display("FAIL rand_count: accepted=%0d, required %0d", acc_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_cmp++;
        if (acc_q[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL rand_byte[%0d]: got %h, required %h", i, acc_q[i], exp[i]);
        end
      end
    end
    tick(2);
    bus_read(ADDR_STATUS, d);
    n_cmp++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL rand_empty: status=%h, required 00000001", d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_hold();
    test_flush();
    test_irq();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
